// File: rtl/sprite_bounce.sv
// sprite_bounce
//   Moves NUM_SPR rectangles around the visible area, one position step per
//   frame, reflecting at the edges. A frame ends when the scan address reaches
//   the last visible pixel. After each frame end a small sequencer updates one
//   sprite per clock, so a single adder/compare path serves every sprite.
//
// Build option:
//   SPRITE_WRAP_EN - sprites wrap around instead of reflecting; the direction
//                    registers stay at zero and fall away in synthesis.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   h_addr, v_addr    current scan column / row
//   en                motion enable (frame events ignored while low)
//   load              one-cycle pulse: reload all sprites from init_x/init_y
//   init_x, init_y    packed start positions, sprite i at [i*W +: W]
//   step_x, step_y    packed per-sprite speeds, pixels per frame
//   pos_x, pos_y      packed current top-left positions
//   edge_x, edge_y    one-cycle pulse per sprite on a bounce (or wrap)
//   busy              update sequence in progress
//   done              one-cycle pulse after the last sprite is updated
//   overrun           sticky: a frame event arrived while busy (cleared by load)
//
// Control priority: load beats a frame tick; a tick seen while busy never
// restarts the sequence, it only raises overrun.
module sprite_bounce #(
    parameter int NUM_SPR = 2,
    parameter int PIC_W   = 100,
    parameter int PIC_H   = 100,
    parameter int H_SIZE  = 640,
    parameter int V_SIZE  = 480,
    parameter int STEP_W  = 4,
    localparam int XW     = $clog2(H_SIZE),
    localparam int YW     = $clog2(V_SIZE)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [XW-1:0]             h_addr,
    input  logic [YW-1:0]             v_addr,
    input  logic                      en,
    input  logic                      load,
    input  logic [NUM_SPR*XW-1:0]     init_x,
    input  logic [NUM_SPR*YW-1:0]     init_y,
    input  logic [NUM_SPR*STEP_W-1:0] step_x,
    input  logic [NUM_SPR*STEP_W-1:0] step_y,
    output logic [NUM_SPR*XW-1:0]     pos_x,
    output logic [NUM_SPR*YW-1:0]     pos_y,
    output logic [NUM_SPR-1:0]        edge_x,
    output logic [NUM_SPR-1:0]        edge_y,
    output logic                      busy,
    output logic                      done,
    output logic                      overrun
);

    localparam int XMAX = H_SIZE - PIC_W;
    localparam int YMAX = V_SIZE - PIC_H;
    localparam int IDXW = (NUM_SPR > 1) ? $clog2(NUM_SPR) : 1;
    // One extra bit so position + step never wraps before the compare.
    localparam int AW   = ((XW > YW) ? XW : YW) + 1;

    typedef enum logic [0:0] {IDLE, UPDATE} state_t;

    typedef struct packed {
        logic [AW-1:0] pos;
        logic          dir;
        logic          hit;
    } axis_t;

    // One axis step. dir=0 moves toward larger coordinates.
    function automatic axis_t axis_step(input logic [AW-1:0]     p,
                                        input logic              d,
                                        input logic [STEP_W-1:0] st,
                                        input logic [AW-1:0]     lim);
        axis_t         r;
        logic [AW-1:0] st_w;
        logic [AW-1:0] s;
        st_w  = AW'(st);
        s     = p + st_w;
        r.pos = p;
        r.dir = d;
        r.hit = 1'b0;
        // A zero speed holds the sprite even when it sits on a limit.
        if (st != '0) begin
`ifdef SPRITE_WRAP_EN
            r.dir = 1'b0;
            if (s > lim) begin
                r.pos = s - (lim + AW'(1));
                r.hit = 1'b1;
            end else begin
                r.pos = s;
            end
`else
            if (!d) begin
                if (s >= lim) begin
                    r.pos = lim;
                    r.dir = 1'b1;
                    r.hit = 1'b1;
                end else begin
                    r.pos = s;
                end
            end else if (p <= st_w) begin
                r.pos = '0;
                r.dir = 1'b0;
                r.hit = 1'b1;
            end else begin
                r.pos = p - st_w;
            end
`endif
        end
        return r;
    endfunction

    logic [XW-1:0]      pos_x_q [NUM_SPR];
    logic [XW-1:0]      pos_x_d [NUM_SPR];
    logic [YW-1:0]      pos_y_q [NUM_SPR];
    logic [YW-1:0]      pos_y_d [NUM_SPR];
    logic [XW-1:0]      init_cx [NUM_SPR];
    logic [YW-1:0]      init_cy [NUM_SPR];
    logic [NUM_SPR-1:0] dir_x_q, dir_x_d, dir_y_q, dir_y_d;
    logic [NUM_SPR-1:0] edge_x_q, edge_x_d, edge_y_q, edge_y_d;
    logic [IDXW-1:0]    idx_q, idx_d;
    state_t             state_q, state_d;
    logic               fv_d_q, fv_d_d;
    logic               done_q, done_d;
    logic               overrun_q, overrun_d;
    logic               fv, tick;
    axis_t              rx, ry;

    // Rising edge of "last visible pixel" gives one tick per frame even when
    // the scan address dwells there for several clocks.
    assign fv   = (h_addr == XW'(H_SIZE - 1)) && (v_addr == YW'(V_SIZE - 1));
    assign tick = fv & ~fv_d_q;

    // Start positions clamped into the legal range; shared by reset and load.
    always_comb begin
        for (int i = 0; i < NUM_SPR; i++) begin
            init_cx[i] = (AW'(init_x[i*XW +: XW]) > AW'(XMAX)) ? XW'(XMAX) : init_x[i*XW +: XW];
            init_cy[i] = (AW'(init_y[i*YW +: YW]) > AW'(YMAX)) ? YW'(YMAX) : init_y[i*YW +: YW];
        end
    end

    always_comb begin
        pos_x_d   = pos_x_q;
        pos_y_d   = pos_y_q;
        dir_x_d   = dir_x_q;
        dir_y_d   = dir_y_q;
        edge_x_d  = '0;
        edge_y_d  = '0;
        done_d    = 1'b0;
        overrun_d = overrun_q;
        state_d   = state_q;
        idx_d     = idx_q;
        fv_d_d    = fv;
        rx        = '0;
        ry        = '0;
        if (load) begin
            for (int i = 0; i < NUM_SPR; i++) begin
                pos_x_d[i] = init_cx[i];
                pos_y_d[i] = init_cy[i];
            end
            dir_x_d   = '0;
            dir_y_d   = '0;
            overrun_d = 1'b0;
            state_d   = IDLE;
            idx_d     = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (tick && en) begin
                        state_d = UPDATE;
                        idx_d   = '0;
                    end
                end
                UPDATE: begin
                    if (tick) overrun_d = 1'b1;
                    rx = axis_step(AW'(pos_x_q[idx_q]), dir_x_q[idx_q],
                                   step_x[int'(idx_q)*STEP_W +: STEP_W], AW'(XMAX));
                    ry = axis_step(AW'(pos_y_q[idx_q]), dir_y_q[idx_q],
                                   step_y[int'(idx_q)*STEP_W +: STEP_W], AW'(YMAX));
                    pos_x_d[idx_q]  = rx.pos[XW-1:0];
                    pos_y_d[idx_q]  = ry.pos[YW-1:0];
                    dir_x_d[idx_q]  = rx.dir;
                    dir_y_d[idx_q]  = ry.dir;
                    edge_x_d[idx_q] = rx.hit;
                    edge_y_d[idx_q] = ry.hit;
                    if (idx_q == IDXW'(NUM_SPR - 1)) begin
                        state_d = IDLE;
                        idx_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + IDXW'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_SPR; i++) begin
                pos_x_q[i] <= init_cx[i];
                pos_y_q[i] <= init_cy[i];
            end
            dir_x_q   <= '0;
            dir_y_q   <= '0;
            edge_x_q  <= '0;
            edge_y_q  <= '0;
            idx_q     <= '0;
            state_q   <= IDLE;
            fv_d_q    <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            pos_x_q   <= pos_x_d;
            pos_y_q   <= pos_y_d;
            dir_x_q   <= dir_x_d;
            dir_y_q   <= dir_y_d;
            edge_x_q  <= edge_x_d;
            edge_y_q  <= edge_y_d;
            idx_q     <= idx_d;
            state_q   <= state_d;
            fv_d_q    <= fv_d_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        pos_x = '0;
        pos_y = '0;
        for (int i = 0; i < NUM_SPR; i++) begin
            pos_x[i*XW +: XW] = pos_x_q[i];
            pos_y[i*YW +: YW] = pos_y_q[i];
        end
    end

    assign edge_x  = edge_x_q;
    assign edge_y  = edge_y_q;
    assign busy    = (state_q == UPDATE);
    assign done    = done_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_sprite_bounce.sv
// Directed bench for sprite_bounce with the default 640x480 / 100x100 / 2-sprite
// configuration (XMAX=540, YMAX=380). Inputs change 1 ns after a rising edge;
// outputs are read at that same point, when they have settled.
module tb_sprite_bounce;

    localparam int NUM_SPR = 2;
    localparam int XW      = 10;
    localparam int YW      = 9;
    localparam int STEP_W  = 4;

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic [XW-1:0]             h_addr = '0;
    logic [YW-1:0]             v_addr = '0;
    logic                      en = 1'b1;
    logic                      load = 1'b0;
    logic [NUM_SPR*XW-1:0]     init_x = '0;
    logic [NUM_SPR*YW-1:0]     init_y = '0;
    logic [NUM_SPR*STEP_W-1:0] step_x = '0;
    logic [NUM_SPR*STEP_W-1:0] step_y = '0;
    logic [NUM_SPR*XW-1:0]     pos_x;
    logic [NUM_SPR*YW-1:0]     pos_y;
    logic [NUM_SPR-1:0]        edge_x, edge_y;
    logic                      busy, done, overrun;

    int vec_cnt = 0;
    int err_cnt = 0;

    logic [NUM_SPR-1:0] ex_or, ey_or;
    int                 ex_hi, ey_hi;
    logic [31:0]        exp_q[$];
    logic [31:0]        exp_v;

    sprite_bounce #(.NUM_SPR(NUM_SPR)) dut (
        .clk(clk), .rst(rst), .h_addr(h_addr), .v_addr(v_addr), .en(en), .load(load),
        .init_x(init_x), .init_y(init_y), .step_x(step_x), .step_y(step_y),
        .pos_x(pos_x), .pos_y(pos_y), .edge_x(edge_x), .edge_y(edge_y),
        .busy(busy), .done(done), .overrun(overrun)
    );

    // ---- clock / watchdog ----
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---- checking ----
    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        vec_cnt++;
        if (got !== want) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    function automatic int px(input int i);
        return int'(pos_x[i*XW +: XW]);
    endfunction

    function automatic int py(input int i);
        return int'(pos_y[i*YW +: YW]);
    endfunction

    // ---- drivers ----
    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input int x0, input int x1, input int y0, input int y1);
        init_x = {XW'(x1), XW'(x0)};
        init_y = {YW'(y1), YW'(y0)};
        load   = 1'b1;
        next_cyc();
        load   = 1'b0;
    endtask

    // One frame event, then enough cycles for the whole update to finish.
    // Collects which edge pulses appeared and for how many cycles.
    task automatic frame();
        h_addr = XW'(639);
        v_addr = YW'(479);
        next_cyc();
        h_addr = '0;
        v_addr = '0;
        ex_or = '0;
        ey_or = '0;
        ex_hi = 0;
        ey_hi = 0;
        repeat (4) begin
            ex_or |= edge_x;
            ey_or |= edge_y;
            ex_hi += $countones(edge_x);
            ey_hi += $countones(edge_y);
            next_cyc();
        end
    endtask

    initial begin
        logic [NUM_SPR-1:0] exp_e [3];

        // ---- reset ----
        init_x = {10'd200, 10'd10};
        init_y = {9'd50, 9'd0};
        repeat (3) next_cyc();
        rst = 1'b0;
        check_val("rst_x0", px(0), 10);
        check_val("rst_x1", px(1), 200);
        check_val("rst_y0", py(0), 0);
        check_val("rst_y1", py(1), 50);
        check_val("rst_flags", {edge_x, edge_y, busy, done, overrun}, 0);

        rst = 1'b1;
        init_x = {10'd200, 10'd600};
        init_y = {9'd50, 9'd470};
        repeat (2) next_cyc();
        rst = 1'b0;
        check_val("rst_clamp_x0", px(0), 540);
        check_val("rst_clamp_y0", py(0), 380);
        next_cyc();

`ifndef SPRITE_WRAP_EN
        // ---- bounce at the right edge ----
        do_load(536, 0, 0, 0);
        step_x = {4'd0, 4'd3};
        step_y = '0;
        exp_q.push_back(539);
        exp_q.push_back(540);
        exp_q.push_back(537);
        exp_e[0] = 2'b00;
        exp_e[1] = 2'b01;
        exp_e[2] = 2'b00;
        for (int f = 0; f < 3; f++) begin
            frame();
            exp_v = exp_q.pop_front();
            check_val($sformatf("bounce_x0_f%0d", f), px(0), exp_v);
            check_val($sformatf("bounce_ex_f%0d", f), ex_or, exp_e[f]);
            check_val($sformatf("bounce_exhi_f%0d", f), ex_hi, $countones(exp_e[f]));
        end

        // ---- low edge on y for sprite 1 ----
        step_x = '0;
        do_load(0, 0, 0, 370);
        step_y = {4'd15, 4'd0};
        frame();
        check_val("low_y1_top", py(1), 380);
        check_val("low_ey_top", ey_or, 2'b10);
        for (int f = 0; f < 25; f++) frame();
        check_val("low_y1_desc", py(1), 5);
        step_y = {4'd3, 4'd0};
        frame();
        check_val("low_y1_2", py(1), 2);
        step_y = {4'd5, 4'd0};
        frame();
        check_val("low_y1_0", py(1), 0);
        check_val("low_ey", ey_or, 2'b10);
        check_val("low_eyhi", ey_hi, 1);
        frame();
        check_val("low_y1_up", py(1), 5);
        check_val("low_ey_none", ey_or, 0);
`else
        // ---- wrap ----
        do_load(539, 0, 0, 0);
        step_x = {4'd0, 4'd4};
        step_y = '0;
        frame();
        check_val("wrap_x0", px(0), 2);
        check_val("wrap_ex", ex_or, 2'b01);
        frame();
        check_val("wrap_x0_next", px(0), 6);
        check_val("wrap_ex_next", ex_or, 0);
`endif

        // ---- sequencing, exact cycles; second tick while busy ----
        do_load(100, 200, 0, 50);
        step_x = {4'd2, 4'd3};
        step_y = '0;
        h_addr = XW'(639);             // cycle T: tick
        v_addr = YW'(479);
        next_cyc();                    // T+1
        h_addr = '0;
        v_addr = '0;
        check_val("seq_busy_t1", busy, 1);
        check_val("seq_done_t1", done, 0);
        check_val("seq_x0_t1", px(0), 100);
        next_cyc();                    // T+2
        h_addr = XW'(639);             // tick while busy
        v_addr = YW'(479);
        check_val("seq_busy_t2", busy, 1);
        check_val("seq_x0_t2", px(0), 103);
        check_val("seq_x1_t2", px(1), 200);
        check_val("seq_ovr_t2", overrun, 0);
        next_cyc();                    // T+3
        h_addr = '0;
        v_addr = '0;
        check_val("seq_busy_t3", busy, 0);
        check_val("seq_done_t3", done, 1);
        check_val("seq_x1_t3", px(1), 202);
        check_val("seq_ovr_t3", overrun, 1);
        next_cyc();                    // T+4
        check_val("seq_done_t4", done, 0);
        repeat (4) next_cyc();
        check_val("seq_x0_once", px(0), 103);
        check_val("seq_x1_once", px(1), 202);
        check_val("seq_ovr_sticky", overrun, 1);

        // ---- en low ignores frames ----
        en = 1'b0;
        for (int f = 0; f < 3; f++) frame();
        check_val("en0_x0", px(0), 103);
        check_val("en0_x1", px(1), 202);
        check_val("en0_busy", busy, 0);
        en = 1'b1;

        // ---- load during UPDATE ----
        h_addr = XW'(639);
        v_addr = YW'(479);
        next_cyc();
        h_addr = '0;
        v_addr = '0;
        check_val("ldmid_busy_before", busy, 1);
        init_x = {10'd60, 10'd50};
        init_y = {9'd7, 9'd9};
        load = 1'b1;
        next_cyc();
        load = 1'b0;
        check_val("ldmid_busy", busy, 0);
        check_val("ldmid_x0", px(0), 50);
        check_val("ldmid_x1", px(1), 60);
        check_val("ldmid_y0", py(0), 9);
        check_val("ldmid_ovr", overrun, 0);
        repeat (4) next_cyc();
        check_val("ldmid_x0_hold", px(0), 50);
        check_val("ldmid_x1_hold", px(1), 60);

        // ---- zero speed on the limit ----
        do_load(600, 0, 0, 0);
        step_x = '0;
        step_y = '0;
        check_val("z_x0_clamp", px(0), 540);
        frame();
        check_val("z_x0", px(0), 540);
        check_val("z_ex", ex_or, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/sprite_bounce.md
# sprite_bounce

Multi-sprite successor to the single-picture bounce mover in the VGA path. Keeps NUM_SPR independent rectangles moving at programmable per-axis speeds inside the visible area. Positions advance once per frame, detected from the scan address, with reflection at the edges. A small sequencer updates one sprite per clock after each frame end, so the adder and compare logic is shared. Sits between the VGA scan counter and the pixel compositor, which reads `pos_x`/`pos_y` to place each picture.

## Interface
Parameters:
- NUM_SPR, 2, number of sprites (1..16)
- PIC_W, 100, sprite width in pixels
- PIC_H, 100, sprite height in pixels
- H_SIZE, 640, visible width
- V_SIZE, 480, visible height
- STEP_W, 4, width of each per-axis speed field

Derived widths and limits:
- XW = $clog2(H_SIZE), YW = $clog2(V_SIZE)
- XMAX = H_SIZE-PIC_W, YMAX = V_SIZE-PIC_H

Ports:
- clk in 1: single clock; every register updates on its rising edge
- rst in 1: synchronous, active-high reset
- h_addr in XW: current scan column
- v_addr in YW: current scan row
- en in 1: motion enable; while low, frame events are ignored
- load in 1: single-cycle pulse that reloads all sprites from the init inputs
- init_x in NUM_SPR*XW: start columns; sprite i is at [i*XW +: XW]
- init_y in NUM_SPR*YW: start rows
- step_x in NUM_SPR*STEP_W: per-sprite horizontal speed in pixels per frame
- step_y in NUM_SPR*STEP_W: per-sprite vertical speed
- pos_x out NUM_SPR*XW: current top-left columns
- pos_y out NUM_SPR*YW: current top-left rows
- edge_x out NUM_SPR: one-cycle pulse on a horizontal bounce (or wrap)
- edge_y out NUM_SPR: one-cycle pulse on a vertical bounce (or wrap)
- busy out 1: high while the update sequence runs
- done out 1: one-cycle pulse after the last sprite is updated
- overrun out 1: sticky flag; a frame event arrived while busy

## Operation
- Frame event: `fv = (h_addr==H_SIZE-1)&&(v_addr==V_SIZE-1)`; `tick = fv & ~fv_d`, where fv_d is a register. This rising-edge detect gives exactly one tick per frame even when the pixel enable is slower than clk.
- FSM states are IDLE and UPDATE.
  - IDLE -> UPDATE on `tick & en & ~load`; idx is set to 0.
  - In UPDATE, one sprite (idx) is processed per cycle. idx==NUM_SPR-1 -> IDLE with a done pulse; otherwise idx increments.
- Per-axis update, shown for x (y is identical with YMAX); dir=0 means +, dir=1 means -.
  - + direction: s = x + step, computed at XW+1 bits. If s >= XMAX: x=XMAX, dir=1, edge pulse. Else x=s.
  - - direction: if x <= step: x=0, dir=0, edge pulse. Else x=x-step.
  - step==0: position is held, no flip, no pulse, even when x sits at a limit.
- Speed fields are sampled in the cycle the sprite is processed.
- load, from any state: every sprite's position takes the init value clamped to [0,XMAX]/[0,YMAX]; all dirs go to +; FSM goes to IDLE; busy is cleared. overrun is cleared. load has priority over tick.
- A tick while busy does not restart the sequence and sets overrun.
- en falling during UPDATE does not abort the sequence in progress.

## Timing
- Reset values:
  - pos_x and pos_y take the clamped init inputs.
  - dirs are 0; fv_d is 0; state is IDLE; idx is 0.
  - edge_x, edge_y, busy, done and overrun are all 0.
- Because fv_d resets to 0, a frame event already present when reset ends produces a tick.
- Tick at cycle T: busy is high from T+1 through T+NUM_SPR.
- Sprite i's new position and its edge pulse are visible from cycle T+2+i. Edge pulses last one cycle.
- done is high in cycle T+1+NUM_SPR; busy is low in that same cycle.
- The minimum tick spacing without overrun is NUM_SPR+1 cycles.

## Configuration
- SPRITE_WRAP_EN defined: no reflection; dirs stay +.
  - s > XMAX gives x = s-(XMAX+1) and pulses edge_x; Y behaves the same.
  - The dir registers are optimised away.
- SPRITE_WRAP_EN undefined: bounce behaviour as specified in Operation.

## Test plan
- Reset: init_x={200,10}, init_y={50,0} -> pos outputs equal the init values and all flags are 0. Init x=600 -> pos_x=540.
- Bounce: sprite0 at x=536 with step_x=3, one tick -> x=539. Next tick -> x=540, edge_x[0]=1 for one cycle. Next tick -> x=537.
- Low edge: sprite1 at y=2 moving - with step_y=5, tick -> y=0 and edge_y[1] pulses. Next tick -> y=5.
- Sequencing: NUM_SPR=2, tick at T -> busy at T+1..T+2, sprite0 changes at T+2, sprite1 at T+3, done at T+3. A second tick at T+1 -> overrun=1 and only one update occurs.
- Control: en=0 with 3 frame events -> positions unchanged. load asserted mid-UPDATE -> positions equal init and busy=0 next cycle. step=0 at x=540 -> no edge pulse.
- Wrap (SPRITE_WRAP_EN): x=539, step=4 -> x=2 and edge_x pulses.
